// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

    localparam int unsigned UART_DATA_W    = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_DIV_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    // Parity bit that makes the total count of ones even (or odd when odd=1).
    function automatic logic parityBit(input logic [UART_DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO; pointers carry an extra wrap bit so full/empty/level fall out of the difference.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] wrData,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] rdData,
    output logic                   full,
    output logic                   empty,
    output logic [LVL_W-1:0]       level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]            wrPtr;
    logic [AW:0]            rdPtr;
    logic [UART_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + (AW+1)'(1);
            if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wrPtr[AW-1:0]] <= wrData;
    end

    assign rdData = mem[rdPtr[AW-1:0]];
    assign level  = LVL_W'(wrPtr - rdPtr);
    assign empty  = (wrPtr == rdPtr);
    assign full   = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit scheduler: FIFO-fed frame sequencer paced by a pclk baud divider.
// Optional line-break state enabled by defining UART_TX_BREAK_EN (adds break_i).
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   dr_wr_en_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic                   tx_en_i,
    input  logic [DIV_W-1:0]       baud_div_i,
    input  logic                   parity_en_i,
    input  logic                   parity_odd_i,
    input  logic                   stop2_i,
`ifdef UART_TX_BREAK_EN
    input  logic                   break_i,
`endif
    output logic                   txd_o,
    output logic                   busy_o,
    output logic                   fifo_full_o,
    output logic                   fifo_empty_o,
    output logic [LVL_W-1:0]       fifo_level_o,
    output logic                   overrun_o
);

    localparam int unsigned IDX_W = $clog2(UART_DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_W - 1);

    tx_state_e              state;
    logic [UART_DATA_W-1:0] shiftReg;
    logic [UART_DATA_W-1:0] popData;
    logic [IDX_W-1:0]       bitIdx;
    logic [DIV_W-1:0]       baudCnt;
    logic [DIV_W-1:0]       divHold;
    logic                   parEnHold;
    logic                   parBitHold;
    logic                   stop2Hold;
    logic                   stopLeft;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   popC;
    logic                   pushC;
    logic                   bitEnd;

`ifdef UART_TX_BREAK_EN
    assign popC = (state == IDLE) && tx_en_i && !fifoEmpty && !break_i;
`else
    assign popC = (state == IDLE) && tx_en_i && !fifoEmpty;
`endif
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign pushC  = dr_wr_en_i && (!fifoFull || popC);
    assign bitEnd = (baudCnt == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .pclk    (pclk),
        .presetn (presetn),
        .push    (pushC),
        .wrData  (wdata_i),
        .pop     (popC),
        .rdData  (popData),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .level   (fifo_level_o)
    );

    assign fifo_full_o  = fifoFull;
    assign fifo_empty_o = fifoEmpty;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) overrun_o <= 1'b0;
        else          overrun_o <= dr_wr_en_i && !pushC;
    end

    // Frame sequencer; line settings are latched at pop and held for the whole frame.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            shiftReg   <= '0;
            bitIdx     <= '0;
            baudCnt    <= '0;
            divHold    <= '0;
            parEnHold  <= 1'b0;
            parBitHold <= 1'b0;
            stop2Hold  <= 1'b0;
            stopLeft   <= 1'b0;
            txd_o      <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            if (state inside {START, DATA, PARITY, STOP})
                baudCnt <= bitEnd ? divHold : baudCnt - DIV_W'(1);

            case (state)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (break_i) begin
                        state  <= BREAK;
                        txd_o  <= 1'b0;
                        busy_o <= 1'b1;
                    end else
`endif
                    if (popC) begin
                        state      <= START;
                        txd_o      <= 1'b0;
                        busy_o     <= 1'b1;
                        shiftReg   <= popData;
                        parBitHold <= parityBit(popData, parity_odd_i);
                        parEnHold  <= parity_en_i;
                        stop2Hold  <= stop2_i;
                        divHold    <= baud_div_i;
                        baudCnt    <= baud_div_i;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        state  <= DATA;
                        bitIdx <= '0;
                        txd_o  <= shiftReg[0];
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        if (bitIdx == LAST_IDX) begin
                            if (parEnHold) begin
                                state <= PARITY;
                                txd_o <= parBitHold;
                            end else begin
                                state    <= STOP;
                                txd_o    <= 1'b1;
                                stopLeft <= stop2Hold;
                            end
                        end else begin
                            shiftReg <= shiftReg >> 1;
                            txd_o    <= shiftReg[1];
                            bitIdx   <= bitIdx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bitEnd) begin
                        state    <= STOP;
                        txd_o    <= 1'b1;
                        stopLeft <= stop2Hold;
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        if (stopLeft) begin
                            stopLeft <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            txd_o  <= 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (!break_i) begin
                        state  <= IDLE;
                        txd_o  <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    txd_o  <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side scheduler for the UART.
- Accepts data-register writes from the APB register-control path into a TX FIFO.
- Sequences the FIFO into a serial frame: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Paced by an internal baud divider on the APB clock. Sits between the register-control block and the txd pad.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of two, at least 2.
- DIV_W, 16, width of the baud divisor.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the FIFO level output (derived).

Ports:
- pclk  in  1  APB clock; all logic on the rising edge.
- presetn  in  1  asynchronous active-low reset.
- dr_wr_en_i  in  1  DR write strobe from register control; one push per cycle high.
- wdata_i  in  8  write data; bits [7:0] of the APB write data.
- tx_en_i  in  1  transmitter enable.
- baud_div_i  in  DIV_W  pclk cycles per bit, minus 1.
- parity_en_i  in  1  parity bit enable.
- parity_odd_i  in  1  1 = odd parity, 0 = even parity.
- stop2_i  in  1  1 = two stop bits.
- txd_o  out  1  serial output; idle high.
- busy_o  out  1  a frame is in progress.
- fifo_full_o  out  1  FIFO full.
- fifo_empty_o  out  1  FIFO empty.
- fifo_level_o  out  LVL_W  number of FIFO entries.
- overrun_o  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset values (async, presetn low):
  - txd_o=1, busy_o=0, fifo_empty_o=1, fifo_full_o=0, fifo_level_o=0, overrun_o=0.
  - FSM=IDLE, baud counter=0, FIFO pointers=0.
  - Takes effect immediately, including mid-frame; the partial frame is discarded.
- FIFO push:
  - A write is accepted when dr_wr_en_i=1 and (!full or pop in the same cycle).
  - Otherwise the write is dropped and overrun_o pulses on the next cycle.
  - Level updates one cycle after push/pop; simultaneous push and pop leaves the level unchanged.
- Pop: only in IDLE, when tx_en_i=1 and !empty. The popped byte is loaded into an 8-bit shift register.
- Frame-start sampling: baud_div_i, parity_en_i, parity_odd_i and stop2_i are sampled at pop and held for the whole frame. Mid-frame changes have no effect.
- Baud counter:
  - Loaded with the sampled divisor at each bit start and decremented every cycle.
  - A bit ends when the counter reaches 0, so each bit lasts divisor+1 cycles.
  - Divisor 0 gives 1 cycle per bit.
- FSM states:
  - IDLE: txd=1, busy=0. Pop goes to START.
  - START: txd=0. Bit end goes to DATA with bit index 0.
  - DATA: txd = shift register [0]. Bit end shifts right; at index 7 go to PARITY if parity enabled, else STOP.
  - PARITY: txd = XOR of the 8 data bits, inverted if odd parity. Bit end goes to STOP.
  - STOP: txd=1. Lasts 1 bit, or 2 bits if stop2. Goes to IDLE.
- busy_o is 1 in every state except IDLE.
- Latency: push in cycle N (FIFO empty, IDLE, tx_en=1) → fifo_empty_o low in N+1 → pop in N+1 → txd_o falls in N+2.
- Back-to-back frames: a STOP→IDLE cycle always occurs, so there is exactly 1 extra idle-high cycle between frames.
- tx_en_i deasserted mid-frame: the current frame completes, then the FSM stays in IDLE. FIFO contents are retained.
- txd_o is registered, with no combinational path from any input.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Adds input port break_i (1 bit).
  - break_i=1 sampled in IDLE enters state BREAK: txd_o=0, busy_o=1, no pops.
  - break_i=0 returns to IDLE.
  - break_i asserted mid-frame takes effect only after STOP.
- When undefined: no break_i port and no BREAK state; the behaviour is otherwise identical.

Decomposition:
- Package uart_tx_pkg holds:
  - the tx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - UART_DATA_W=8;
  - default FIFO_DEPTH and DIV_W constants.
- Sub-module uart_tx_fifo: synchronous FIFO.
  - Parameterised depth and width 8.
  - Provides push, pop, full, empty and level, with an extra pointer wrap bit.
  - Same pclk/presetn.

Test Plan:
- Single byte: divisor=3, no parity, 1 stop, write 0xA5 → txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. Frame is 40 cycles; busy_o high for exactly 40 cycles.
- Parity: divisor=0, parity_en=1, write 0x07. Even mode gives parity bit 1; odd mode gives parity bit 0. stop2=1 gives 2 stop cycles, so the frame is 12 cycles.
- FIFO full/overrun: tx_en=0, 17 writes 0x00..0x10 with depth 16 → level 16, full=1, overrun_o pulses once. Enabling tx_en then transmits 0x00..0x0F in order.
- Push and pop same cycle at full: push lands on the pop cycle → accepted, no overrun, level stays 16.
- Mid-frame: change divisor 3→7 after START → the frame keeps 4-cycle bits. Deassert tx_en with 2 bytes queued → the current frame ends, then level stays 2.
- Reset mid-DATA: presetn low → txd_o=1 and busy_o=0 in the same cycle, level=0. After release, no residual transmission.
